// File: rtl/cpi_pkg.sv
// Shared types and defaults for the CPI agent-side link endpoint.
package cpi_pkg;

   typedef enum logic [2:0] {
      LINK_IDLE,
      LINK_CONN,
      LINK_UP,
      LINK_DISC,
      LINK_FATAL
   } link_state_e;

   localparam logic [3:0] PID_CXL_CACHE = 4'h1;
   localparam logic [3:0] PID_CXL_MEM   = 4'h2;
   localparam logic [3:0] PID_CXL_IO    = 4'h3;

   localparam int unsigned CPI_HDR_W  = 129;
   localparam int unsigned CPI_DATA_W = 128;
   localparam int unsigned CPI_BE_W   = 4;

endpackage

// File: rtl/cpi_tag_tracker.sv
// In-flight tag vector with lowest-free-tag allocation and tag retirement.
module cpi_tag_tracker
   import cpi_pkg::*;
#(
   parameter int unsigned MAX_OUTST = 8,
   parameter int unsigned TAG_W     = $clog2(MAX_OUTST)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 alloc_i,
   input  logic                 retire_i,
   input  logic [TAG_W-1:0]     retire_tag_i,
   output logic [TAG_W-1:0]     free_tag_o,
   output logic                 full_o,
   output logic [MAX_OUTST-1:0] in_flight_o,
   output logic [TAG_W:0]       cnt_o
);

   localparam logic [TAG_W:0] CNT_ONE = 1;

   logic [MAX_OUTST-1:0] in_flight_q, in_flight_d;
   logic [TAG_W:0]       cnt_q, cnt_d;
   logic                 retire_hit;

   assign retire_hit = retire_i & in_flight_q[retire_tag_i];

   // Scan downward so the last assignment wins with the lowest free index.
   always_comb begin
      free_tag_o = '0;
      for (int unsigned i = MAX_OUTST; i > 0; i--) begin
         if (!in_flight_q[i-1]) free_tag_o = TAG_W'(i - 1);
      end
   end

   always_comb begin
      in_flight_d = in_flight_q;
      if (alloc_i)    in_flight_d[free_tag_o]   = 1'b1;
      if (retire_hit) in_flight_d[retire_tag_i] = 1'b0;
   end

   always_comb begin
      cnt_d = cnt_q;
      unique case ({alloc_i, retire_hit})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         in_flight_q <= '0;
         cnt_q       <= '0;
      end else begin
         in_flight_q <= in_flight_d;
         cnt_q       <= cnt_d;
      end
   end

   assign full_o      = &in_flight_q;
   assign in_flight_o = in_flight_q;
   assign cnt_o       = cnt_q;

endmodule

// File: rtl/cpi_agent_initiator.sv
// Agent-side CPI endpoint: link handshake FSM, A2F request/data issue,
// tag tracking and F2A response / read-data return to the client.
module cpi_agent_initiator
   import cpi_pkg::*;
#(
   parameter int unsigned HDR_W        = CPI_HDR_W,
   parameter int unsigned DATA_W       = CPI_DATA_W,
   parameter int unsigned BE_W         = CPI_BE_W,
   parameter int unsigned MAX_OUTST    = 8,
   parameter int unsigned TAG_W        = $clog2(MAX_OUTST),
   parameter int unsigned CONN_TIMEOUT = 1024
) (
   input  logic              ag_clk,
   input  logic              ag_rst,
   input  logic              link_en,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_protocol_id,
   input  logic [HDR_W-1:0]  cmd_header,
   input  logic              cmd_has_data,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   input  logic [DATA_W-1:0] wdata_body,
   input  logic [BE_W-1:0]   wdata_byte_en,
   input  logic              wdata_eop,
   output logic              a2f_txcon_req,
   input  logic              a2f_rxcon_ack,
   input  logic              a2f_rxdiscon_nack,
   input  logic              a2f_rx_empty,
   output logic              a2f_fatal,
   input  logic              f2a_txcon_req,
   output logic              f2a_rxcon_ack,
   output logic              f2a_rxdiscon_nack,
   output logic              f2a_rx_empty,
   input  logic              f2a_fatal,
   output logic              a2f_req_is_valid,
   output logic [3:0]        a2f_req_protocol_id,
   output logic [HDR_W-1:0]  a2f_req_header,
   output logic              a2f_rsp_is_valid,
   output logic [3:0]        a2f_rsp_protocol_id,
   output logic [HDR_W-1:0]  a2f_rsp_header,
   input  logic              a2f_rsp_excrd_valid,
   output logic              a2f_data_is_valid,
   output logic [3:0]        a2f_data_protocol_id,
   output logic [DATA_W-1:0] a2f_data_header,
   output logic [DATA_W-1:0] a2f_data_body,
   output logic [BE_W-1:0]   a2f_data_byte_en,
   output logic              a2f_data_poison,
   output logic              a2f_data_parity,
   output logic              a2f_data_eop,
   input  logic              f2a_rsp_is_valid,
   input  logic [3:0]        f2a_rsp_protocol_id,
   input  logic [HDR_W-1:0]  f2a_rsp_header,
   output logic              f2a_rsp_excrd_valid,
   input  logic              f2a_data_is_valid,
   input  logic [3:0]        f2a_data_protocol_id,
   input  logic [DATA_W-1:0] f2a_data_header,
   input  logic [DATA_W-1:0] f2a_data_body,
   input  logic [BE_W-1:0]   f2a_data_byte_en,
   input  logic              f2a_data_poison,
   input  logic              f2a_data_parity,
   input  logic              f2a_data_eop,
   output logic              rsp_valid,
   output logic [3:0]        rsp_protocol_id,
   output logic [HDR_W-1:0]  rsp_header,
   output logic              rsp_err,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_body,
   output logic [BE_W-1:0]   rd_byte_en,
   output logic              rd_eop,
   output logic              rd_poison,
   output logic              link_up,
   output logic              link_fatal,
   output logic              conn_timeout,
   output logic [TAG_W:0]    outst_cnt
);

   localparam int unsigned TMR_W = $clog2(CONN_TIMEOUT + 1);

   link_state_e          link_q, link_d;
   logic [TMR_W-1:0]     conn_tmr_q, conn_tmr_d;
   logic                 tmr_expired, fatal_evt;
   logic                 cmd_accept, beat_accept;
   logic                 trk_full;
   logic [TAG_W-1:0]     free_tag;
   logic [MAX_OUTST-1:0] in_flight;
   logic [HDR_W-1:0]     issued_hdr;

   logic                 burst_q, conn_timeout_q, f2a_ack_q, rx_empty_q;
   logic [3:0]           burst_pid_q;
   logic [DATA_W-1:0]    burst_hdr_q;
   logic                 req_valid_q;
   logic [3:0]           req_pid_q;
   logic [HDR_W-1:0]     req_hdr_q;
   logic                 dat_valid_q, dat_par_q, dat_eop_q;
   logic [3:0]           dat_pid_q;
   logic [DATA_W-1:0]    dat_hdr_q, dat_body_q;
   logic [BE_W-1:0]      dat_be_q;
   logic                 rsp_valid_q, rsp_err_q;
   logic [3:0]           rsp_pid_q;
   logic [HDR_W-1:0]     rsp_hdr_q;
   logic                 rd_valid_q, rd_eop_q, rd_poison_q;
   logic [DATA_W-1:0]    rd_body_q;
   logic [BE_W-1:0]      rd_be_q;
   logic                 unused_inputs;

   assign tmr_expired = (conn_tmr_q == TMR_W'(CONN_TIMEOUT - 1));
   assign fatal_evt   = f2a_fatal | (f2a_data_is_valid & (f2a_data_parity != ^f2a_data_body));
   assign cmd_accept  = cmd_valid & cmd_ready;
   assign beat_accept = wdata_valid & wdata_ready;
   assign issued_hdr  = {cmd_header[HDR_W-1:TAG_W], free_tag};

   always_ff @(posedge ag_clk or negedge ag_rst) begin
      if (!ag_rst) link_q <= LINK_IDLE;
      else         link_q <= link_d;
   end

   always_comb begin
      link_d = link_q;
      if (fatal_evt) begin
         link_d = LINK_FATAL;
      end else begin
         unique case (link_q)
            LINK_IDLE: if (link_en) link_d = LINK_CONN;
            LINK_CONN: begin
               if (a2f_rxcon_ack)    link_d = LINK_UP;
               else if (tmr_expired) link_d = LINK_IDLE;
            end
            LINK_UP:   if (!link_en && outst_cnt == '0 && !burst_q) link_d = LINK_DISC;
            LINK_DISC: begin
               if (a2f_rxdiscon_nack)   link_d = LINK_UP;
               else if (!a2f_rxcon_ack) link_d = LINK_IDLE;
            end
            LINK_FATAL: link_d = LINK_FATAL;
            default:    link_d = LINK_IDLE;
         endcase
      end
   end

   always_comb begin
      a2f_txcon_req = (link_q == LINK_CONN) || (link_q == LINK_UP);
      link_up       = (link_q == LINK_UP);
      a2f_fatal     = (link_q == LINK_FATAL);
      link_fatal    = (link_q == LINK_FATAL);
      cmd_ready     = (link_q == LINK_UP) && !trk_full && !burst_q;
      wdata_ready   = burst_q && (link_q != LINK_FATAL);
      f2a_rxcon_ack = f2a_ack_q && (link_q != LINK_FATAL);
   end

   assign conn_tmr_d = (link_q == LINK_CONN) ? conn_tmr_q + TMR_W'(1) : '0;

   cpi_tag_tracker #(
      .MAX_OUTST (MAX_OUTST),
      .TAG_W     (TAG_W)
   ) u_tags (
      .clk_i        (ag_clk),
      .rst_ni       (ag_rst),
      .alloc_i      (cmd_accept),
      .retire_i     (f2a_rsp_is_valid),
      .retire_tag_i (f2a_rsp_header[TAG_W-1:0]),
      .free_tag_o   (free_tag),
      .full_o       (trk_full),
      .in_flight_o  (in_flight),
      .cnt_o        (outst_cnt)
   );

   // The data header mirrors the request header, zero-extended or truncated to DATA_W.
   always_ff @(posedge ag_clk or negedge ag_rst) begin
      if (!ag_rst) begin
         conn_tmr_q     <= '0;
         conn_timeout_q <= 1'b0;
         f2a_ack_q      <= 1'b0;
         rx_empty_q     <= 1'b0;
         burst_q        <= 1'b0;
         burst_pid_q    <= '0;
         burst_hdr_q    <= '0;
         req_valid_q    <= 1'b0;
         req_pid_q      <= '0;
         req_hdr_q      <= '0;
         dat_valid_q    <= 1'b0;
         dat_pid_q      <= '0;
         dat_hdr_q      <= '0;
         dat_body_q     <= '0;
         dat_be_q       <= '0;
         dat_par_q      <= 1'b0;
         dat_eop_q      <= 1'b0;
         rsp_valid_q    <= 1'b0;
         rsp_err_q      <= 1'b0;
         rsp_pid_q      <= '0;
         rsp_hdr_q      <= '0;
         rd_valid_q     <= 1'b0;
         rd_body_q      <= '0;
         rd_be_q        <= '0;
         rd_eop_q       <= 1'b0;
         rd_poison_q    <= 1'b0;
      end else begin
         conn_tmr_q     <= conn_tmr_d;
         conn_timeout_q <= (link_q == LINK_CONN) && tmr_expired && !a2f_rxcon_ack && !fatal_evt;
         f2a_ack_q      <= f2a_txcon_req;
         rx_empty_q     <= !(f2a_rsp_is_valid || f2a_data_is_valid);

         if (cmd_accept && cmd_has_data) begin
            burst_q     <= 1'b1;
            burst_pid_q <= cmd_protocol_id;
            burst_hdr_q <= DATA_W'(issued_hdr);
         end else if (beat_accept && wdata_eop) begin
            burst_q <= 1'b0;
         end

         req_valid_q <= cmd_accept;
         if (cmd_accept) begin
            req_pid_q <= cmd_protocol_id;
            req_hdr_q <= issued_hdr;
         end

         dat_valid_q <= beat_accept;
         if (beat_accept) begin
            dat_pid_q  <= burst_pid_q;
            dat_hdr_q  <= burst_hdr_q;
            dat_body_q <= wdata_body;
            dat_be_q   <= wdata_byte_en;
            dat_par_q  <= ^wdata_body;
            dat_eop_q  <= wdata_eop;
         end

         rsp_valid_q <= f2a_rsp_is_valid;
         if (f2a_rsp_is_valid) begin
            rsp_err_q <= !in_flight[f2a_rsp_header[TAG_W-1:0]];
            rsp_pid_q <= f2a_rsp_protocol_id;
            rsp_hdr_q <= f2a_rsp_header;
         end

         rd_valid_q <= f2a_data_is_valid;
         if (f2a_data_is_valid) begin
            rd_body_q   <= f2a_data_body;
            rd_be_q     <= f2a_data_byte_en;
            rd_eop_q    <= f2a_data_eop;
            rd_poison_q <= f2a_data_poison;
         end
      end
   end

   assign conn_timeout         = conn_timeout_q;
   assign f2a_rx_empty         = rx_empty_q;
   assign f2a_rxdiscon_nack    = 1'b0;
   assign f2a_rsp_excrd_valid  = 1'b0;
   assign a2f_rsp_is_valid     = 1'b0;
   assign a2f_rsp_protocol_id  = '0;
   assign a2f_rsp_header       = '0;
   assign a2f_req_is_valid     = req_valid_q;
   assign a2f_req_protocol_id  = req_pid_q;
   assign a2f_req_header       = req_hdr_q;
   assign a2f_data_is_valid    = dat_valid_q;
   assign a2f_data_protocol_id = dat_pid_q;
   assign a2f_data_header      = dat_hdr_q;
   assign a2f_data_body        = dat_body_q;
   assign a2f_data_byte_en     = dat_be_q;
   assign a2f_data_poison      = 1'b0;
   assign a2f_data_parity      = dat_par_q;
   assign a2f_data_eop         = dat_eop_q;
   assign rsp_valid            = rsp_valid_q;
   assign rsp_protocol_id      = rsp_pid_q;
   assign rsp_header           = rsp_hdr_q;
   assign rsp_err              = rsp_err_q;
   assign rd_valid             = rd_valid_q;
   assign rd_body              = rd_body_q;
   assign rd_byte_en           = rd_be_q;
   assign rd_eop               = rd_eop_q;
   assign rd_poison            = rd_poison_q;

   assign unused_inputs = &{1'b0, a2f_rx_empty, a2f_rsp_excrd_valid, f2a_data_protocol_id,
                            f2a_data_header, cmd_header[TAG_W-1:0]};

endmodule

// File: doc/cpi_agent_initiator.md
# cpi_agent_initiator

Agent-side endpoint of the CPI link that faces `fabric_manager`. It runs the global-layer connect/disconnect handshake in both directions and turns a local command stream into A2F request and data transfers. It also tracks outstanding transactions by tag and returns F2A responses and read data to the local client. It sits between a CXL.mem agent core and the fabric manager's A2F inputs and F2A outputs.

## Interface
Parameters:
- `HDR_W`, 129, request/response header width.
- `DATA_W`, 128, data body width (data header is also `DATA_W`).
- `BE_W`, 4, byte-enable width.
- `MAX_OUTST`, 8, outstanding-request limit; power of two.
- `TAG_W`, $clog2(MAX_OUTST), tag field in header bits [TAG_W-1:0].
- `CONN_TIMEOUT`, 1024, cycles to wait for connect ack.

Ports:
- `ag_clk` in 1: clock.
- `ag_rst` in 1: asynchronous, active-low reset.
- `link_en` in 1: request link up (1) or down (0).
- `cmd_valid`/`cmd_ready` in/out 1: command handshake.
- `cmd_protocol_id` in 4, `cmd_header` in HDR_W, `cmd_has_data` in 1: command fields.
- `wdata_valid`/`wdata_ready` in/out 1; `wdata_body` in DATA_W; `wdata_byte_en` in BE_W; `wdata_eop` in 1: write beats.
- `a2f_txcon_req` out 1; `a2f_rxcon_ack`, `a2f_rxdiscon_nack`, `a2f_rx_empty` in 1; `a2f_fatal` out 1.
- `f2a_txcon_req` in 1; `f2a_rxcon_ack`, `f2a_rxdiscon_nack`, `f2a_rx_empty` out 1; `f2a_fatal` in 1.
- `a2f_req_is_valid` out 1, `a2f_req_protocol_id` out 4, `a2f_req_header` out HDR_W.
- `a2f_rsp_is_valid` out 1, `a2f_rsp_protocol_id` out 4, `a2f_rsp_header` out HDR_W (tied 0); `a2f_rsp_excrd_valid` in 1 (ignored).
- `a2f_data_is_valid`, `_protocol_id`, `_header`, `_body`, `_byte_en`, `_poison`, `_parity`, `_eop` out: A2F data layer.
- `f2a_rsp_is_valid` in 1, `f2a_rsp_protocol_id` in 4, `f2a_rsp_header` in HDR_W; `f2a_rsp_excrd_valid` out 1 (tied 0).
- `f2a_data_*` in: F2A data layer, same fields as A2F.
- `rsp_valid`, `rsp_protocol_id`, `rsp_header`, `rsp_err` out: response to client.
- `rd_valid`, `rd_body`, `rd_byte_en`, `rd_eop`, `rd_poison` out: read data to client.
- `link_up`, `link_fatal`, `conn_timeout` out 1; `outst_cnt` out TAG_W+1.

## Operation
- Link FSM states:
  - IDLE: `link_en`=1 → CONN.
  - CONN: `a2f_txcon_req`=1. `a2f_rxcon_ack`=1 → UP. Timer reaches CONN_TIMEOUT → IDLE, with a 1-cycle `conn_timeout` pulse.
  - UP: `link_up`=1. `link_en`=0 and `outst_cnt`=0 and no data burst active → DISC.
  - DISC: `a2f_txcon_req`=0. `a2f_rxcon_ack`=0 → IDLE. `a2f_rxdiscon_nack`=1 → UP.
  - FATAL: entered from any state. Exit only by reset.
- F2A side: `f2a_rxcon_ack` follows `f2a_txcon_req` with 1-cycle delay, forced 0 in FATAL. `f2a_rxdiscon_nack` is 0. `f2a_rx_empty`=1 when no response or read beat is pending output.
- `cmd_ready` = UP && `outst_cnt`<MAX_OUTST && no data burst && not FATAL.
- On command accept:
  - Allocate the lowest free tag and overwrite header bits [TAG_W-1:0] with it.
  - Issue the A2F request.
  - If `cmd_has_data`, enter the data burst. `wdata_ready`=1 only in the burst. Each beat drives `a2f_data_*` with `_header` = issued request header, `_parity` = ^body, `_poison`=0. The burst ends on `wdata_eop`.
- On `f2a_rsp_is_valid`:
  - Tag in flight → free it and forward to `rsp_*`.
  - Tag not in flight → `rsp_valid` with `rsp_err`=1; count unchanged.
- Accept and retire in the same cycle leave `outst_cnt` unchanged.
- `f2a_data_*` is registered to `rd_*`.
- FATAL trigger: `f2a_fatal`, or `f2a_data_parity` != ^`f2a_data_body` on a valid beat. `a2f_fatal` and `link_fatal` are then sticky 1, and `cmd_ready`/`wdata_ready` are 0.

## Timing
- Every output resets to 0; FSM resets to IDLE; all tags reset to free.
- Command accept → `a2f_req_is_valid` 1 cycle later, high exactly 1 cycle.
- Write beat accept → `a2f_data_is_valid` 1 cycle later.
- `f2a_rsp_is_valid` → `rsp_valid` 1 cycle later. `f2a_data_is_valid` → `rd_valid` 1 cycle later. The client never backpressures these.
- `outst_cnt` updates the cycle after accept/retire. Back-to-back accepts are allowed every cycle up to MAX_OUTST.
- Reset mid-burst or mid-handshake: immediate return to IDLE; in-flight tags are discarded.

## Structure
- Package `cpi_pkg`:
  - `link_state_e` enum (IDLE, CONN, UP, DISC, FATAL).
  - Protocol-id constants.
  - Default HDR_W, DATA_W and BE_W localparams.
- Sub-module `cpi_tag_tracker`:
  - MAX_OUTST-bit in-flight vector and lowest-free-tag priority encoder.
  - Allocate/retire ports, count output.

## Test plan
- `link_en`=1, ack after 3 cycles → `link_up`=1 at cycle 5. `link_en`=0 with `outst_cnt`=0 → DISC. Ack drop → IDLE.
- No ack for 1024 cycles → `conn_timeout` pulse, state IDLE, `a2f_txcon_req`=0.
- 8 back-to-back reads → tags 0..7 issued, `cmd_ready`=0 at count 8. One response with tag 3 → count 7. The next accept gets tag 3.
- Write with 4 beats, eop on beat 4 → 4 `a2f_data_is_valid` cycles with correct parity. `cmd_ready`=0 until the cycle after eop.
- Response with tag 5 not in flight → `rsp_err`=1, `outst_cnt` unchanged. Simultaneous accept and retire → count unchanged.
- Bad parity on an F2A data beat → `a2f_fatal`=1 the next cycle, sticky until `ag_rst`=0.
